// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the multi-cycle adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefChunk = 16;

  // Counter width for n chunks; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Narrow combinational adder shared across all chunk cycles.
module chunk_adder #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  // Full CHUNK+1 bit sum; top bit is the carry out.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// File: rtl/seq_adder64.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per RUN cycle.
module seq_adder64
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = clog2(N);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_adder64: WIDTH must be a multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               overflow_q, overflow_d;

  logic [CHUNK-1:0]   a_k, b_k, s_k;
  logic               co_k;
  logic               last;
  logic               cin_msb;

  // Select the operand slices for the chunk currently being processed.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (count_q == CntW'(k)) begin
        a_k = a_q[k*CHUNK +: CHUNK];
        b_k = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a  (a_k),
    .b  (b_k),
    .ci (carry_q),
    .s  (s_k),
    .co (co_k)
  );

  assign last    = (count_q == CntW'(N - 1));
  // Carry into the MSB recovered from the MSB operand bits and sum bit.
  assign cin_msb = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ s_k[CHUNK-1];

  // Next-state and datapath updates; outputs only move when entering DONE.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_d      = sum_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = operand1;
          b_d     = operand2;
          cin_d   = cin;
          count_d = '0;
          carry_d = cin;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < int'(N); k++) begin
          if (count_q == CntW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_k;
          end
        end
        carry_d = co_k;
        if (last) begin
          result_d   = sum_d;
          cout_d     = co_k;
          overflow_d = cin_msb ^ co_k;
          state_d    = StDone;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and working registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      count_q    <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sum_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  // Status decoded directly from the state register.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    result   = result_q;
    cout     = cout_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_seq_adder64.sv
// Directed self-checking bench for seq_adder64.
module tb_seq_adder64;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [63:0] operand1;
  logic [63:0] operand2;
  logic        cin;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        cout;
  logic        overflow;

  int n_cmp;
  int n_err;

  seq_adder64 #(
    .WIDTH (64),
    .CHUNK (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .operand1 (operand1),
    .operand2 (operand2),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a start at the next edge (edge 0).
  task automatic issue(input logic [63:0] o1, input logic [63:0] o2, input logic c);
    operand1 = o1;
    operand2 = o2;
    cin      = c;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Count edges after edge 0 until done, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    operand1 = 64'h1234;
    operand2 = 64'h1;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({busy, done, cout, overflow} !== 4'b0000 || result !== 64'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: busy=%b done=%b cout=%b ovf=%b result=%h, want all zero",
                 i, busy, done, cout, overflow, result);
      end
    end
    start  = 1'b0;
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    issue(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4) begin
      n_err++;
      $display("FAIL ripple_latency: done after %0d edges, want 4", cyc);
    end
    n_cmp++;
    if (result !== 64'h0 || cout !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ripple_value: result=%h cout=%b ovf=%b, want 0/1/0", result, cout, overflow);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ripple_done_pulse: done=%b busy=%b after DONE, want 0/0", done, busy);
    end
  endtask

  task automatic test_cin_cross();
    int cyc;
    issue(64'h00000000_FFFFFFFF, 64'h0, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || result !== 64'h00000001_00000000 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL cin_cross: cyc=%0d result=%h cout=%b ovf=%b, want 4/0000000100000000/0/0",
               cyc, result, cout, overflow);
    end
    tick();
  endtask

  task automatic test_overflow();
    issue(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_cmp++;
      if (result !== 64'h00000001_00000000 || done !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_hold[edge %0d]: result=%h done=%b busy=%b, want 0000000100000000/0/1",
                 e, result, done, busy);
      end
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || result !== 64'h80000000_00000000 || overflow !== 1'b1 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_value: done=%b result=%h ovf=%b cout=%b, want 1/8000000000000000/1/0",
               done, result, overflow, cout);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int dones;
    int cyc;
    dones = 0;
    issue(64'd5, 64'd7, 1'b0);          // edge 0
    tick();                             // edge 1
    operand1 = 64'd100;
    start    = 1'b1;
    tick();                             // edge 2, ignored
    start    = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_busy_e2: busy=%b, want 1", busy);
    end
    for (int e = 3; e <= 5; e++) begin
      tick();
      if (done === 1'b1) dones++;
      if (e == 4) begin
        n_cmp++;
        if (done !== 1'b1 || result !== 64'd12 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL ignore_result: done=%b busy=%b result=%0d, want 1/1/12", done, busy, result);
        end
      end
    end
    n_cmp++;
    if (dones !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_single_done: dones=%0d busy=%b at edge5, want 1/0", dones, busy);
    end
    issue(64'd100, 64'd7, 1'b0);        // edge 6
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_accept: busy=%b after edge 6, want 1", busy);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || result !== 64'd107) begin
      n_err++;
      $display("FAIL restart_result: cyc=%0d result=%0d, want 4/107", cyc, result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    issue(64'd3, 64'd4, 1'b1);          // edge 0
    tick();                             // edge 1
    resetn = 1'b0;
    tick();                             // edge 2
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0/0/0", busy, done, result);
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    n_cmp++;
    if (dones !== 0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: active cycles=%0d result=%h, want 0/0", dones, result);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    operand1 = '0;
    operand2 = '0;
    cin      = 1'b0;
    test_reset();
    test_carry_ripple();
    test_cin_cross();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
